cp0_exception: RTL and testbench

- Coprocessor-0 exception unit. It is the consumer of the ALU's arithmetic-overflow exception and of the other pipeline exception sources.
- Holds Status, Cause, EPC, Count and Compare. Arbitrates exceptions and interrupts at the commit stage, and drives the flush and redirect PC into fetch.
- Services mfc0/mtc0/eret.

---
 rtl/cp0_exception.sv | 171 +++++++++++++++++
 tb/tb_cp0_exception.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exception.sv
// Coprocessor-0 exception unit: Status/Cause/EPC/Count/Compare, commit-stage
// exception and interrupt arbitration, flush/redirect, mfc0/mtc0/eret.
module cp0_exception #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_valid,
    input  logic [31:0] pc_in,
    input  logic        in_delay_slot,
    input  logic        exp_overflow,
    input  logic        exp_syscall,
    input  logic        exp_ri,
    input  logic [5:0]  ext_int,
    input  logic        eret,
    input  logic        mtc0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        exc_flush,
    output logic [31:0] exc_pc
);

    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_STATUS  = 5'd12;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] ADDR_EPC     = 5'd14;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    // Status fields
    logic [7:0]  r_status_im;
    logic        r_status_exl;
    logic        r_status_ie;
    // Cause fields
    logic        r_cause_bd;
    logic [5:0]  r_cause_ip_hw;
    logic [1:0]  r_cause_ip_sw;
    logic [4:0]  r_cause_exccode;
    // Remaining state
    logic [31:0] r_epc;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_timer_pend;

    logic        w_int_req;
    logic        w_exc_valid;
    logic [4:0]  w_exc_code;
    logic        w_eret_take;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic        w_wr_cause;
    logic        w_wr_epc;
    logic [7:0]  w_ip;

    assign w_ip         = {r_cause_ip_hw, r_cause_ip_sw};
    assign w_wr_count   = mtc0_we && (cp0_addr == ADDR_COUNT);
    assign w_wr_compare = mtc0_we && (cp0_addr == ADDR_COMPARE);
    assign w_wr_status  = mtc0_we && (cp0_addr == ADDR_STATUS);
    assign w_wr_cause   = mtc0_we && (cp0_addr == ADDR_CAUSE);
    assign w_wr_epc     = mtc0_we && (cp0_addr == ADDR_EPC);

    // Interrupt request and fixed-priority exception selection
    always_comb begin
        w_int_req   = inst_valid && r_status_ie && !r_status_exl && ((w_ip & r_status_im) != 8'h00);
        w_exc_valid = 1'b1;
        w_exc_code  = EXC_INT;
        if (w_int_req) begin
            w_exc_code = EXC_INT;
        end else if (inst_valid && exp_ri) begin
            w_exc_code = EXC_RI;
        end else if (inst_valid && exp_syscall) begin
            w_exc_code = EXC_SYS;
        end else if (inst_valid && exp_overflow) begin
            w_exc_code = EXC_OV;
        end else begin
            w_exc_valid = 1'b0;
        end
        w_eret_take = inst_valid && eret && !w_exc_valid;
    end

    // Zero-latency flush and redirect target
    always_comb begin
        exc_flush = 1'b0;
        exc_pc    = '0;
        if (w_exc_valid) begin
            exc_flush = 1'b1;
            exc_pc    = EXC_VECTOR;
        end else if (w_eret_take) begin
            exc_flush = 1'b1;
            exc_pc    = r_epc;
        end
    end

    // mfc0 read mux; unimplemented registers read as zero
    always_comb begin
        rdata = '0;
        case (cp0_addr)
            ADDR_COUNT:   rdata = r_count;
            ADDR_COMPARE: rdata = r_compare;
            ADDR_STATUS:  rdata = {16'h0000, r_status_im, 6'b000000, r_status_exl, r_status_ie};
            ADDR_CAUSE:   rdata = {r_cause_bd, 15'h0000, r_cause_ip_hw, r_cause_ip_sw,
                                   1'b0, r_cause_exccode, 2'b00};
            ADDR_EPC:     rdata = r_epc;
            default:      rdata = '0;
        endcase
    end

    // Count/Compare timer; these writes are honoured even under an exception
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count      <= '0;
            r_compare    <= '0;
            r_timer_pend <= 1'b0;
        end else begin
            r_count <= w_wr_count ? wdata : r_count + 32'd1;
            if (w_wr_compare) begin
                r_compare    <= wdata;
                r_timer_pend <= 1'b0;
            end else if (r_count == r_compare) begin
                r_timer_pend <= 1'b1;
            end
        end
    end

    // Status/Cause/EPC update: exception beats eret and mtc0 to these registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_status_im     <= '0;
            r_status_exl    <= 1'b0;
            r_status_ie     <= 1'b0;
            r_cause_bd      <= 1'b0;
            r_cause_ip_hw   <= '0;
            r_cause_ip_sw   <= '0;
            r_cause_exccode <= '0;
            r_epc           <= '0;
        end else begin
            r_cause_ip_hw <= {ext_int[5] | r_timer_pend, ext_int[4:0]};
            if (w_exc_valid) begin
                r_cause_exccode <= w_exc_code;
                r_status_exl    <= 1'b1;
                if (!r_status_exl) begin
                    r_epc      <= in_delay_slot ? pc_in - 32'd4 : pc_in;
                    r_cause_bd <= in_delay_slot;
                end
            end else begin
                if (w_wr_status) begin
                    r_status_im  <= wdata[15:8];
                    r_status_exl <= wdata[1];
                    r_status_ie  <= wdata[0];
                end
                if (w_wr_cause) begin
                    r_cause_ip_sw <= wdata[9:8];
                end
                if (w_wr_epc) begin
                    r_epc <= wdata;
                end
                // eret placed after the Status write so it wins on EXL
                if (w_eret_take) begin
                    r_status_exl <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_exception.sv
// Self-checking bench for cp0_exception: directed scenarios plus randomized
// traffic, all compared against a register-level behavioural model.
module tb_cp0_exception;

    localparam logic [31:0] VEC = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_valid;
    logic [31:0] pc_in;
    logic        in_delay_slot;
    logic        exp_overflow;
    logic        exp_syscall;
    logic        exp_ri;
    logic [5:0]  ext_int;
    logic        eret;
    logic        mtc0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exc_flush;
    logic [31:0] exc_pc;

    always #5 clk = ~clk;

    cp0_exception #(.EXC_VECTOR(VEC)) dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .pc_in(pc_in),
        .in_delay_slot(in_delay_slot), .exp_overflow(exp_overflow),
        .exp_syscall(exp_syscall), .exp_ri(exp_ri), .ext_int(ext_int),
        .eret(eret), .mtc0_we(mtc0_we), .cp0_addr(cp0_addr), .wdata(wdata),
        .rdata(rdata), .exc_flush(exc_flush), .exc_pc(exc_pc)
    );

    // Model state: architectural 32-bit register images
    logic [31:0] m_status, m_cause, m_epc, m_count, m_compare;
    logic        m_tp;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Selected exception code for the current inputs, -1 when none
    function automatic int exc_code();
        if (inst_valid && m_status[0] && !m_status[1] && ((m_cause[15:8] & m_status[15:8]) != 8'h00))
            return 0;
        if (inst_valid && exp_ri)       return 10;
        if (inst_valid && exp_syscall)  return 8;
        if (inst_valid && exp_overflow) return 12;
        return -1;
    endfunction

    function automatic logic [31:0] model_rdata();
        case (cp0_addr)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    // Check outputs for the driven inputs, then advance model and DUT one edge
    task automatic tick();
        int          code;
        logic        e_fl;
        logic [31:0] e_pc;
        logic [31:0] n_status, n_cause, n_epc, n_count, n_compare;
        logic        n_tp;
        #1;
        code = exc_code();
        e_fl = 1'b0;
        e_pc = 32'h0;
        if (code >= 0) begin
            e_fl = 1'b1;
            e_pc = VEC;
        end else if (eret && inst_valid) begin
            e_fl = 1'b1;
            e_pc = m_epc;
        end
        check("rdata", rdata, model_rdata());
        check("exc_flush", {31'b0, exc_flush}, {31'b0, e_fl});
        check("exc_pc", exc_pc, e_pc);

        if (!rst_n) begin
            n_status = 0; n_cause = 0; n_epc = 0; n_count = 0; n_compare = 0; n_tp = 1'b0;
        end else begin
            n_status  = m_status;
            n_cause   = m_cause;
            n_epc     = m_epc;
            n_count   = m_count + 1;
            n_compare = m_compare;
            n_tp      = m_tp || (m_count == m_compare);
            if (mtc0_we && cp0_addr == 5'd9) n_count = wdata;
            if (mtc0_we && cp0_addr == 5'd11) begin
                n_compare = wdata;
                n_tp      = 1'b0;
            end
            if (code >= 0) begin
                n_cause[6:2] = code[4:0];
                if (!m_status[1]) begin
                    n_epc       = in_delay_slot ? pc_in - 4 : pc_in;
                    n_cause[31] = in_delay_slot;
                end
                n_status[1] = 1'b1;
            end else begin
                if (mtc0_we && cp0_addr == 5'd12) n_status = wdata & 32'h0000FF03;
                if (mtc0_we && cp0_addr == 5'd13) n_cause[9:8] = wdata[9:8];
                if (mtc0_we && cp0_addr == 5'd14) n_epc = wdata;
                if (eret && inst_valid) n_status[1] = 1'b0;
            end
            n_cause[15:10] = {ext_int[5] | m_tp, ext_int[4:0]};
        end
        @(posedge clk);
        m_status = n_status; m_cause = n_cause; m_epc = n_epc;
        m_count = n_count; m_compare = n_compare; m_tp = n_tp;
        @(negedge clk);
    endtask

    task automatic idle();
        rst_n = 1'b1; inst_valid = 1'b0; pc_in = 32'h0; in_delay_slot = 1'b0;
        exp_overflow = 1'b0; exp_syscall = 1'b0; exp_ri = 1'b0; ext_int = 6'h0;
        eret = 1'b0; mtc0_we = 1'b0; cp0_addr = 5'd0; wdata = 32'h0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle(); mtc0_we = 1'b1; cp0_addr = a; wdata = d; tick(); idle();
    endtask

    task automatic do_eret(input logic [31:0] exp_target);
        idle(); inst_valid = 1'b1; eret = 1'b1;
        #1; check("eret_flush", {31'b0, exc_flush}, 32'd1);
        check("eret_pc", exc_pc, exp_target);
        tick(); idle();
    endtask

    logic [4:0] addr_tab [8] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd31, 5'd8};

    initial begin
        m_status = 0; m_cause = 0; m_epc = 0; m_count = 0; m_compare = 0; m_tp = 1'b0;
        idle();
        @(negedge clk);

        // Reset and Count after three idle cycles
        rst_n = 1'b0; tick(); idle();
        tick(); tick(); tick();
        cp0_addr = 5'd9; #1; check("count_3", rdata, 32'd3); tick();
        cp0_addr = 5'd12; #1; check("status_rst", rdata, 32'h0); tick();
        cp0_addr = 5'd14; #1; check("epc_rst", rdata, 32'h0); tick();
        mtc0(5'd11, 32'hFFFF0000);

        // Overflow, not in delay slot
        inst_valid = 1'b1; exp_overflow = 1'b1; pc_in = 32'h00400010;
        #1; check("ov_flush", {31'b0, exc_flush}, 32'd1); check("ov_pc", exc_pc, VEC);
        tick(); idle();
        cp0_addr = 5'd14; #1; check("ov_epc", rdata, 32'h00400010); tick();
        cp0_addr = 5'd13; #1; check("ov_cause", rdata, 32'h00000030); tick();
        cp0_addr = 5'd12; #1; check("ov_exl", {31'b0, rdata[1]}, 32'd1); tick();
        do_eret(32'h00400010);
        cp0_addr = 5'd12; #1; check("eret_exl", {31'b0, rdata[1]}, 32'd0); tick();

        // Nested exception with EXL=1 keeps EPC
        inst_valid = 1'b1; exp_overflow = 1'b1; pc_in = 32'h00400010; tick(); idle();
        inst_valid = 1'b1; exp_overflow = 1'b1; pc_in = 32'h00400100; tick(); idle();
        cp0_addr = 5'd14; #1; check("nest_epc", rdata, 32'h00400010); tick();
        do_eret(32'h00400010);

        // Syscall in a delay slot
        inst_valid = 1'b1; exp_syscall = 1'b1; pc_in = 32'h00400024; in_delay_slot = 1'b1;
        tick(); idle();
        cp0_addr = 5'd14; #1; check("sys_epc", rdata, 32'h00400020); tick();
        cp0_addr = 5'd13; #1; check("sys_cause", rdata, 32'h80000020); tick();
        do_eret(32'h00400020);

        // RI beats syscall
        inst_valid = 1'b1; exp_syscall = 1'b1; exp_ri = 1'b1; pc_in = 32'h00400040;
        tick(); idle();
        cp0_addr = 5'd13; #1; check("ri_code", {27'b0, rdata[6:2]}, 32'd10); tick();
        do_eret(32'h00400040);

        // Hardware interrupt 0 beats a simultaneous overflow
        mtc0(5'd12, 32'h00000401);
        ext_int = 6'h01; tick();
        cp0_addr = 5'd13; #1; check("ip2", {31'b0, rdata[10]}, 32'd1); tick();
        inst_valid = 1'b1; exp_overflow = 1'b1; pc_in = 32'h00400080;
        #1; check("int_flush", {31'b0, exc_flush}, 32'd1); check("int_pc", exc_pc, VEC);
        tick(); idle(); ext_int = 6'h01;
        cp0_addr = 5'd13; #1; check("int_code", {27'b0, rdata[6:2]}, 32'd0); tick();
        do_eret(32'h00400080);
        mtc0(5'd12, 32'h00000400);
        ext_int = 6'h01; tick();
        ext_int = 6'h01; inst_valid = 1'b1;
        #1; check("ie0_noflush", {31'b0, exc_flush}, 32'd0); tick(); idle();

        // Timer interrupt
        mtc0(5'd9, 32'h0);
        mtc0(5'd11, 32'd5);
        cp0_addr = 5'd13;
        for (int i = 0; i < 8; i++) tick();
        #1; check("tmr_ip7", {31'b0, rdata[15]}, 32'd1); tick();
        mtc0(5'd12, 32'h00008001);
        inst_valid = 1'b1; pc_in = 32'h00400200;
        #1; check("tmr_flush", {31'b0, exc_flush}, 32'd1); tick(); idle();
        do_eret(32'h00400200);
        mtc0(5'd11, 32'h00100000);
        tick();
        cp0_addr = 5'd13; #1; check("tmr_clr", {31'b0, rdata[15]}, 32'd0); tick();
        mtc0(5'd12, 32'h0);

        // Count wrap
        mtc0(5'd9, 32'hFFFFFFFF);
        cp0_addr = 5'd9; #1; check("cnt_max", rdata, 32'hFFFFFFFF); tick();
        #1; check("cnt_wrap", rdata, 32'h0); tick();

        // Reset while EXL=1
        inst_valid = 1'b1; exp_overflow = 1'b1; pc_in = 32'h00400300; tick(); idle();
        rst_n = 1'b0; tick(); idle();
        cp0_addr = 5'd12; #1; check("rst_status", rdata, 32'h0);
        check("rst_flush", {31'b0, exc_flush}, 32'd0); tick();
        cp0_addr = 5'd13; #1; check("rst_cause", rdata, 32'h0); tick();
        cp0_addr = 5'd14; #1; check("rst_epc", rdata, 32'h0); tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n         = ($urandom_range(0, 299) != 0);
            inst_valid    = ($urandom_range(0, 3) != 0);
            exp_overflow  = ($urandom_range(0, 15) == 0);
            exp_syscall   = ($urandom_range(0, 15) == 0);
            exp_ri        = ($urandom_range(0, 15) == 0);
            eret          = ($urandom_range(0, 5) == 0);
            in_delay_slot = 1'($urandom_range(0, 1));
            pc_in         = $urandom & 32'hFFFFFFFC;
            ext_int       = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'h0;
            mtc0_we       = ($urandom_range(0, 4) == 0);
            cp0_addr      = addr_tab[$urandom_range(0, 7)];
            wdata         = $urandom;
            if (cp0_addr == 5'd11 && $urandom_range(0, 1) == 1)
                wdata = m_count + 32'($urandom_range(0, 6));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
